// File: rtl/sha256_stream_hasher.sv
// Runtime-length SHA-256 engine: streams a message from word memory, pads it on the fly,
// hashes one round per clock and writes the 8-word digest back over the shared memory bus.
module sha256_stream_hasher #(
  parameter int unsigned MAX_WORDS = 1024,
  parameter int unsigned ADDR_W    = 16
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             start,
  input  logic [ADDR_W-1:0]                message_addr,
  input  logic [ADDR_W-1:0]                output_addr,
  input  logic [$clog2(MAX_WORDS+1)-1:0]   num_words,
  output logic                             done,
  output logic                             mem_clk,
  output logic                             mem_we,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic [31:0]                      mem_write_data,
  input  logic [31:0]                      mem_read_data
);

  localparam int unsigned NW_W  = $clog2(MAX_WORDS + 1);
  localparam int unsigned P_W   = NW_W + 1;
  localparam int unsigned BLK_W = P_W - 4;

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, UPDATE, WRITE} state_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  state_t              state, state_n;
  logic [6:0]          cnt, cnt_n;
  logic                done_n, mem_we_n;
  logic [ADDR_W-1:0]   mem_addr_n;
  logic [31:0]         mem_write_data_n;

  logic [ADDR_W-1:0]   msg_q, out_q;
  logic [NW_W-1:0]     n_q;
  logic [BLK_W-1:0]    last_q, blk;
  logic [31:0]         hh [8];
  logic [31:0]         v  [8];
  logic [31:0]         w  [16];

  logic [NW_W-1:0]     n_clamp;
  logic [BLK_W-1:0]    last_calc;
  logic [P_W-1:0]      p_rd, p_cap, p_nblk;
  logic [31:0]         cap_word, t1, t2, w_new;

  assign mem_clk = clk;

  assign n_clamp   = (32'(num_words) > MAX_WORDS) ? NW_W'(MAX_WORDS) : num_words;
  assign last_calc = BLK_W'((32'(n_clamp) + 32'd2) >> 4);

  // Padded-word indices: next read address, word being captured, first word of the next block
  assign p_rd   = {blk, 4'(cnt[3:0] + 4'd1)};
  assign p_cap  = {blk, 4'(cnt[3:0] - 4'd1)};
  assign p_nblk = {BLK_W'(blk + BLK_W'(1)), 4'd0};

  always_comb begin
    if (p_cap < P_W'(n_q))
      cap_word = mem_read_data;
    else if (p_cap == P_W'(n_q))
      cap_word = 32'h8000_0000;
    else if ((blk == last_q) && (p_cap[3:0] == 4'hF))
      cap_word = 32'({n_q, 5'b0});
    else
      cap_word = 32'h0;
  end

  // One compression round and the rolling message-schedule extension
  always_comb begin
    t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
              + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_TAB[cnt[5:0]] + w[0];
    t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
       + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
    w_new = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
          + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      done           <= 1'b1;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      done           <= done_n;
      mem_we         <= mem_we_n;
      mem_addr       <= mem_addr_n;
      mem_write_data <= mem_write_data_n;
    end
  end

  // Bus outputs are computed one cycle ahead so they register alongside the state
  always_comb begin
    state_n          = state;
    cnt_n            = cnt;
    done_n           = done;
    mem_we_n         = 1'b0;
    mem_addr_n       = mem_addr;
    mem_write_data_n = mem_write_data;
    case (state)
      IDLE: begin
        done_n = 1'b1;
        if (start) begin
          state_n = LOAD;
          cnt_n   = '0;
          done_n  = 1'b0;
          if (n_clamp != '0) mem_addr_n = message_addr;
        end
      end
      LOAD: begin
        if (cnt == 7'd16) begin
          state_n = COMPUTE;
          cnt_n   = '0;
        end else begin
          cnt_n = 7'(cnt + 7'd1);
          if ((cnt < 7'd15) && (p_rd < P_W'(n_q))) mem_addr_n = msg_q + ADDR_W'(p_rd);
        end
      end
      COMPUTE: begin
        if (cnt == 7'd63) begin
          state_n = UPDATE;
          cnt_n   = '0;
        end else begin
          cnt_n = 7'(cnt + 7'd1);
        end
      end
      UPDATE: begin
        cnt_n = '0;
        if (blk < last_q) begin
          state_n = LOAD;
          if (p_nblk < P_W'(n_q)) mem_addr_n = msg_q + ADDR_W'(p_nblk);
        end else begin
          state_n          = WRITE;
          mem_we_n         = 1'b1;
          mem_addr_n       = out_q;
          mem_write_data_n = hh[0] + v[0];
        end
      end
      WRITE: begin
        if (cnt == 7'd7) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          cnt_n            = 7'(cnt + 7'd1);
          mem_we_n         = 1'b1;
          mem_addr_n       = out_q + ADDR_W'(7'(cnt + 7'd1));
          mem_write_data_n = hh[3'(cnt[2:0] + 3'd1)];
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath: latched job parameters, chaining value, working variables, schedule window
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      msg_q  <= '0;
      out_q  <= '0;
      n_q    <= '0;
      last_q <= '0;
      blk    <= '0;
      for (int i = 0; i < 8; i++) begin
        hh[i] <= IV[i];
        v[i]  <= '0;
      end
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            msg_q  <= message_addr;
            out_q  <= output_addr;
            n_q    <= n_clamp;
            last_q <= last_calc;
            blk    <= '0;
            for (int i = 0; i < 8; i++) hh[i] <= IV[i];
          end
        end
        LOAD: begin
          if (cnt == 7'd0) begin
            for (int i = 0; i < 8; i++) v[i] <= hh[i];
          end else begin
            w[p_cap[3:0]] <= cap_word;
          end
        end
        COMPUTE: begin
          v[7] <= v[6];
          v[6] <= v[5];
          v[5] <= v[4];
          v[4] <= v[3] + t1;
          v[3] <= v[2];
          v[2] <= v[1];
          v[1] <= v[0];
          v[0] <= t1 + t2;
          for (int i = 0; i < 15; i++) w[i] <= w[i+1];
          w[15] <= w_new;
        end
        UPDATE: begin
          for (int i = 0; i < 8; i++) hh[i] <= hh[i] + v[i];
          blk <= BLK_W'(blk + BLK_W'(1));
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_stream_hasher.sv
// Bench for sha256_stream_hasher: word memory model, reference SHA-256 over padded queues,
// and a write monitor that checks every digest write against the expected stream.
module tb_sha256_stream_hasher;

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] message_addr = '0;
  logic [15:0] output_addr = '0;
  logic [10:0] num_words = '0;
  logic        done, mem_clk, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data = '0;

  logic [31:0] mem [65536];
  logic [15:0] exp_addr [$];
  logic [31:0] exp_data [$];
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  sha256_stream_hasher dut (
    .clk(clk), .reset_n(reset_n), .start(start), .message_addr(message_addr),
    .output_addr(output_addr), .num_words(num_words), .done(done), .mem_clk(mem_clk),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  // Synchronous-read memory: data for an address appears the cycle after it is driven
  always @(posedge clk) mem_read_data <= mem[mem_addr];

  function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha256_ref(input logic [31:0] msg [$]);
    logic [31:0] p [$];
    logic [31:0] h [8];
    logic [31:0] v [8];
    logic [31:0] w [64];
    logic [31:0] t1, t2, bits;
    bits = 32'(msg.size() * 32);
    p = msg;
    p.push_back(32'h8000_0000);
    while ((p.size() % 16) != 14) p.push_back(32'h0);
    p.push_back(32'h0);
    p.push_back(bits);
    for (int i = 0; i < 8; i++) h[i] = IV[i];
    for (int b = 0; b < p.size() / 16; b++) begin
      for (int t = 0; t < 64; t++) begin
        if (t < 16) w[t] = p[16*b + t];
        else w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                  + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      end
      for (int i = 0; i < 8; i++) v[i] = h[i];
      for (int t = 0; t < 64; t++) begin
        t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
                  + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
        t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
        for (int i = 7; i > 0; i--) v[i] = v[i-1];
        v[4] = v[4] + t1;
        v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) h[i] = h[i] + v[i];
    end
    return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
  endfunction

  // Every write strobe must match the next expected digest word and address
  always @(negedge clk) begin
    if (reset_n && mem_we) begin
      if (exp_addr.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required no write", mem_addr, mem_write_data);
      end else begin
        chk("write", 256'({mem_addr, mem_write_data}), 256'({exp_addr.pop_front(), exp_data.pop_front()}));
      end
    end
  end

  task automatic prepare(input logic [15:0] ma, input logic [15:0] oa, input int n, input bit abcd);
    logic [31:0] q [$];
    logic [31:0] word;
    logic [255:0] d;
    int nc;
    nc = (n > 1024) ? 1024 : n;
    for (int i = 0; i < nc; i++) begin
      word = abcd ? 32'h6162_6364 : $urandom;
      mem[16'(ma + 16'(i))] = word;
      q.push_back(word);
    end
    d = sha256_ref(q);
    for (int k = 0; k < 8; k++) begin
      exp_addr.push_back(16'(oa + 16'(k)));
      exp_data.push_back(d[255 - 32*k -: 32]);
    end
    message_addr = ma;
    output_addr  = oa;
    num_words    = 11'(n);
  endtask

  task automatic wait_done(input int exp_lat, input int pulse_at, input string name);
    int c;
    bit seen;
    c = 0;
    seen = 1'b0;
    while (!seen && c <= exp_lat + 20) begin
      @(posedge clk);
      c++;
      #1;
      if (pulse_at != 0) start = (c == pulse_at);
      seen = done;
    end
    chk({name, "_latency"}, 256'(seen ? c : 0), 256'(exp_lat));
  endtask

  task automatic go(input logic [15:0] ma, input logic [15:0] oa, input int n, input bit abcd,
                    input int exp_lat, input int pulse_at, input string name);
    prepare(ma, oa, n, abcd);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(exp_lat, pulse_at, name);
    chk({name, "_writes_left"}, 256'(exp_addr.size()), 256'(0));
  endtask

  initial begin
    logic [31:0] q [$];
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_done", 256'(done), 256'(1));
    chk("reset_we", 256'(mem_we), 256'(0));
    chk("reset_addr", 256'(mem_addr), 256'(0));
    chk("reset_wdata", 256'(mem_write_data), 256'(0));
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    chk("model_empty", sha256_ref(q),
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855);
    q.push_back(32'h6162_6364);
    chk("model_abcd", sha256_ref(q),
        256'h88d4266fd4e6338d13b845fcf289579d209c897823b9217da3e161936f031589);

    go(16'h0100, 16'h2000, 0, 1'b0, 90, 0, "n0");
    go(16'h0200, 16'h2010, 1, 1'b1, 90, 0, "abcd");
    go(16'h0300, 16'h2020, 13, 1'b0, 90, 0, "n13");
    go(16'h0400, 16'h2030, 14, 1'b0, 172, 0, "n14");
    go(16'hFFF8, 16'h2040, 20, 1'b0, 172, 0, "n20_wrap");
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(0, 70);
      go(16'($urandom_range(0, 65535)), 16'h5000 + 16'(16 * r), n, 1'b0,
         82 * ((n + 2) / 16 + 1) + 8, 0, "rand");
    end
    go(16'h0800, 16'h2050, 1500, 1'b0, 5338, 0, "clamp");
    go(16'h0500, 16'h2060, 20, 1'b0, 172, 40, "pulse");

    // Start held high across done: second job launches from the single IDLE cycle
    prepare(16'h1000, 16'h2070, 5, 1'b0);
    start = 1'b1;
    @(posedge clk);
    #1;
    prepare(16'h3000, 16'h2080, 16, 1'b0);
    wait_done(90, 0, "hold_a");
    @(posedge clk);
    #1;
    chk("hold_relaunch", 256'(done), 256'(0));
    start = 1'b0;
    wait_done(172, 0, "hold_b");
    chk("hold_writes_left", 256'(exp_addr.size()), 256'(0));

    // Abort mid-COMPUTE; no digest writes may follow
    message_addr = 16'h0600;
    output_addr  = 16'h20A0;
    num_words    = 11'd20;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("abort_we", 256'(mem_we), 256'(0));
    chk("abort_done", 256'(done), 256'(1));
    chk("abort_addr", 256'(mem_addr), 256'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    go(16'h0700, 16'h2090, 0, 1'b0, 90, 0, "after_reset");

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
